// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM states and requester ids for the data memory arbiter
package data_mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-requester arbiter for a single-port data memory
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic             b_req,
  input  logic             a_we,
  input  logic             b_we,
  input  logic [Width-1:0] a_addr,
  input  logic [Width-1:0] b_addr,
  input  logic [Width-1:0] a_wdata,
  input  logic [Width-1:0] b_wdata,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic             a_done,
  output logic             b_done,
  output logic             a_err,
  output logic             b_err,
  output logic [Width-1:0] a_rdata,
  output logic [Width-1:0] b_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [Width-1:0] mem_addr,
  output logic [Width-1:0] mem_wdata,
  input  logic [Width-1:0] mem_rdata
);
  state_t state, state_n;
  logic id, last, we_q, win, arb, acc, rsp, in_range;
  logic [Width-1:0] addr_q, wdata_q, a_rd, b_rd;
  function automatic logic pick(input logic a, input logic b, input logic l);
    return (a && b) ? ~l : (b ? REQ_B : REQ_A);
  endfunction
  always_comb begin
    acc      = state == ACCESS;
    rsp      = state == RESP;
    arb      = !acc && (a_req || b_req);
    win      = pick(a_req, b_req, last);
    in_range = addr_q < Width'(Depth);
    state_n  = acc ? RESP : (arb ? ACCESS : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last    <= REQ_B;
      id      <= REQ_A;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      a_rd    <= '0;
      b_rd    <= '0;
    end else begin
      state <= state_n;
      if (arb) begin
        id      <= win;
        last    <= win;
        we_q    <= win ? b_we : a_we;
        addr_q  <= win ? b_addr : a_addr;
        wdata_q <= win ? b_wdata : a_wdata;
      end
      // out-of-range and write accesses leave the requester's read data untouched
      if (acc && !we_q && in_range) begin
        if (id == REQ_B) b_rd <= mem_rdata;
        else a_rd <= mem_rdata;
      end
    end
  end
  always_comb begin
    a_gnt     = acc && id == REQ_A;
    b_gnt     = acc && id == REQ_B;
    a_done    = rsp && id == REQ_A;
    b_done    = rsp && id == REQ_B;
    a_err     = a_done && !in_range;
    b_err     = b_done && !in_range;
    mem_read  = acc && !we_q && in_range;
    mem_write = acc && we_q && in_range;
    mem_addr  = acc ? addr_q : '0;
    mem_wdata = acc ? wdata_q : '0;
    a_rdata   = a_rd;
    b_rdata   = b_rd;
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: table-driven directed checks plus hand sequences for arbitration and reset abort
module tb_data_mem_arbiter;
  import data_mem_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic a_req = 0, b_req = 0, a_we = 0, b_we = 0;
  logic [31:0] a_addr = 0, b_addr = 0, a_wdata = 0, b_wdata = 0;
  logic a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_read, mem_write;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:511];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  data_mem_arbiter #(.Width(32), .Depth(512)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
    .a_err(a_err), .b_err(b_err), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  // behavioural data memory: combinational read, synchronous write, preloaded on reset
  assign mem_rdata = (mem_addr < 32'd512) ? mem[mem_addr[8:0]] : 32'h0;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h9;
    end else if (mem_write) mem[mem_addr[8:0]] <= mem_wdata;
  end
  typedef struct {
    logic ar, aw; logic [31:0] aa, ad;
    logic br, bw; logic [31:0] ba, bd;
    logic [7:0] fl; logic [31:0] ma, md, ard, brd;
  } vec_t;
  vec_t vecs [15];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] flags();
    return {24'h0, a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_read, mem_write};
  endfunction
  initial begin
    // flags order: a_gnt b_gnt a_done b_done a_err b_err mem_read mem_write
    vecs[0]  = '{1, 0, 4,   0, 0, 0, 0, 0,            8'b1000_0010, 4,   0,            9'h0, 0};
    vecs[1]  = '{0, 0, 0,   0, 0, 0, 0, 0,            8'b0010_0000, 0,   0,            9,    0};
    vecs[2]  = '{0, 0, 0,   0, 1, 1, 7, 32'hDEADBEEF, 8'b0100_0001, 7,   32'hDEADBEEF, 9,    0};
    vecs[3]  = '{0, 0, 0,   0, 0, 0, 0, 0,            8'b0001_0000, 0,   0,            9,    0};
    vecs[4]  = '{0, 0, 0,   0, 1, 0, 7, 0,            8'b0100_0010, 7,   0,            9,    0};
    vecs[5]  = '{0, 0, 0,   0, 0, 0, 0, 0,            8'b0001_0000, 0,   0,            9,    32'hDEADBEEF};
    vecs[6]  = '{1, 0, 512, 0, 0, 0, 0, 0,            8'b1000_0000, 512, 0,            9,    32'hDEADBEEF};
    vecs[7]  = '{0, 0, 0,   0, 0, 0, 0, 0,            8'b0010_1000, 0,   0,            9,    32'hDEADBEEF};
    vecs[8]  = '{0, 0, 0,   0, 0, 0, 0, 0,            8'b0000_0000, 0,   0,            9,    32'hDEADBEEF};
    vecs[9]  = '{0, 0, 0,   0, 1, 0, 4, 0,            8'b0100_0010, 4,   0,            9,    32'hDEADBEEF};
    vecs[10] = '{0, 0, 0,   0, 1, 0, 4, 0,            8'b0001_0000, 0,   0,            9,    9};
    vecs[11] = '{0, 0, 0,   0, 1, 0, 4, 0,            8'b0100_0010, 4,   0,            9,    9};
    vecs[12] = '{0, 0, 0,   0, 1, 0, 4, 0,            8'b0001_0000, 0,   0,            9,    9};
    vecs[13] = '{0, 0, 0,   0, 1, 0, 4, 0,            8'b0100_0010, 4,   0,            9,    9};
    vecs[14] = '{0, 0, 0,   0, 0, 0, 0, 0,            8'b0001_0000, 0,   0,            9,    9};
    step();
    step();
    chk("reset flags", flags(), 0);
    chk("reset a_rdata", a_rdata, 0);
    chk("reset b_rdata", b_rdata, 0);
    chk("reset mem_addr", mem_addr, 0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      a_req = vecs[i].ar; a_we = vecs[i].aw; a_addr = vecs[i].aa; a_wdata = vecs[i].ad;
      b_req = vecs[i].br; b_we = vecs[i].bw; b_addr = vecs[i].ba; b_wdata = vecs[i].bd;
      step();
      chk($sformatf("v%0d flags", i), flags(), {24'h0, vecs[i].fl});
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].ma);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].md);
      chk($sformatf("v%0d a_rdata", i), a_rdata, vecs[i].ard);
      chk($sformatf("v%0d b_rdata", i), b_rdata, vecs[i].brd);
    end
    // both requesters held high from reset: A, B, A, B two cycles apart
    b_req = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    a_req = 1; a_we = 0; a_addr = 4;
    b_req = 1; b_we = 0; b_addr = 7;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rr%0d gnt", k), {30'h0, a_gnt, b_gnt},
          (k % 4 == 0) ? 32'd2 : (k % 4 == 2) ? 32'd1 : 32'd0);
    end
    a_req = 0; b_req = 0;
    step();
    step();
    chk("idle after rr", flags(), 0);
    // reset in the ACCESS cycle of an A write aborts the transaction
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 32'h55;
    step();
    chk("abort access", flags(), 32'h81);
    chk("abort mem_wdata", mem_wdata, 32'h55);
    a_req = 0;
    reset = 1'b1;
    step();
    chk("abort flags", flags(), 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    step();
    chk("abort no done", flags(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter Width, default 32, meaning data and address width in bits.
REQ-002 SHALL have parameter Depth, default 512, meaning number of words in the attached data memory.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports a_req / b_req, input, 1 bit each: access request from requester A (core) and requester B (DMA/debug).
REQ-006 SHALL have ports a_we / b_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports a_addr / b_addr, input, Width each: word address.
REQ-008 SHALL have ports a_wdata / b_wdata, input, Width each: write data.
REQ-009 SHALL have ports a_gnt / b_gnt, output, 1 bit each: request consumed.
REQ-010 SHALL have ports a_done / b_done, output, 1 bit each: response valid.
REQ-011 SHALL have ports a_err / b_err, output, 1 bit each: address out of range, qualified by done.
REQ-012 SHALL have ports a_rdata / b_rdata, output, Width each: read data, qualified by done with we=0.
REQ-013 SHALL have ports mem_read / mem_write, output, 1 bit each: memory strobes, mutually exclusive.
REQ-014 SHALL have ports mem_addr / mem_wdata, output, Width each: memory address and write data.
REQ-015 SHALL have port mem_rdata, input, Width: combinational memory read data.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-017 SHALL arbitrate in IDLE and RESP: on any req, latch winner id, we, addr and wdata at the clock edge, then go to ACCESS; with no req, go to (or stay in) IDLE.
REQ-018 SHALL pick the winner round-robin: a sole requester wins; on simultaneous requests, the requester not granted last wins.
REQ-019 SHALL, in ACCESS, assert the winner's gnt for exactly 1 cycle and drive mem_addr and mem_wdata from the latched values.
REQ-020 SHALL, in ACCESS, assert mem_read (we=0) or mem_write (we=1) for exactly 1 cycle, and only when the latched addr < Depth.
REQ-021 SHALL, in ACCESS, capture mem_rdata into the winner's rdata register at the cycle-end edge, then go to RESP.
REQ-022 SHALL, in RESP, assert the winner's done for 1 cycle; rdata SHALL hold until that requester's next done.
REQ-023 SHALL treat latched addr >= Depth as an error: no memory strobe, err=1 with done, rdata unchanged.
REQ-024 SHALL have fixed latency of req sampled at edge N, gnt in cycle N+1, done in cycle N+2, with back-to-back throughput of 1 access per 2 cycles.
REQ-025 SHALL treat req still high in the cycle after gnt as a new request; requesters drop req the cycle after gnt.
REQ-026 SHALL ignore req changes during ACCESS, since the latched values govern the access.
REQ-027 SHALL drive mem_read=mem_write=0 and gnt=done=err=0 outside the cycles stated above, and SHALL never grant both requesters in the same cycle.

Reset
REQ-028 SHALL, on reset=1 at an edge, enter IDLE; clear all gnt, done, err, mem strobes and rdata registers to 0; and set last-grant to B so that A wins the first conflict.
REQ-029 SHALL, on reset asserted mid-transaction (ACCESS or RESP), abort it: no done is issued, and no mem strobe appears in the following cycle.

Structure
REQ-030 SHALL take the FSM state encoding and requester-id constants (REQ_A=0, REQ_B=1) from shared package data_mem_pkg.
REQ-031 SHALL be a single module with no sub-modules; the round-robin pick is an internal function, and DataMemory is instantiated only in the bench.

Verification
REQ-032 SHALL cover this scenario: memory preloaded with mem[4]=0x9, A reads addr 4 at edge 0 -> a_gnt=1 in cycle 1, mem_read=1 with mem_addr=4 in cycle 1, a_done=1 and a_rdata=0x9 in cycle 2.
REQ-033 SHALL cover this scenario: B writes 0xDEADBEEF to addr 7, then B reads addr 7 -> mem_write pulses 1 cycle, and the read returns 0xDEADBEEF.
REQ-034 SHALL cover this scenario: A and B both request from reset, held high -> grant order A, B, A, B, with gnt pulses 2 cycles apart.
REQ-035 SHALL cover this scenario: A reads addr 512 -> no mem strobe, a_done=1, a_err=1, a_rdata unchanged.
REQ-036 SHALL cover this scenario: reset asserted in the ACCESS cycle of an A write -> no a_done, state IDLE, and all outputs 0 in the next cycle.
REQ-037 SHALL cover this scenario: B requests alone 3 times back-to-back -> B is granted each time, with no starvation penalty.
